fetch_stage: RTL

// - Instruction fetch stage, directly upstream of the decoder.
// - Owns the PC and issues 32-bit instruction reads on the instruction bus.
// - Latches the returned word with its PC into the F/D output register.
// - Presents instr/pc to decode with a valid/ready handshake; accepts PC redirects from execute.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 44 ++++
 rtl/fetch_stage_pc_gen.sv | 23 ++
 rtl/fetch_stage.sv | 99 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional misaligned-PC trap is enabled with FETCH_MISALIGN_EN.
package fetch_stage_pkg;

  localparam int unsigned FETCH_XLEN = 64;
  localparam logic [FETCH_XLEN-1:0] PC_RESET_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]           raw_instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  valid;
  } fetch_data_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus, redirect and fetch/decode handshake bundle.
// out_exc exists only when FETCH_MISALIGN_EN is defined.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
`ifdef FETCH_MISALIGN_EN
  logic            out_exc;
`endif

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_data_ok, iresp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
`ifdef FETCH_MISALIGN_EN
    output out_exc,
`endif
    input  out_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_data_ok, iresp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
`ifdef FETCH_MISALIGN_EN
    input  out_exc,
`endif
    output out_ready
  );

endinterface

// File: rtl/fetch_stage_pc_gen.sv
// Next-PC selection: redirect target beats sequential advance beats hold.
module pc_gen
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues bus reads, feeds the F/D register.
// Define FETCH_MISALIGN_EN to trap misaligned PCs as a nop carrying out_exc.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] stale_addr;
  logic [XLEN-1:0] next_pc;
  logic            handshake;
  logic            misalign;
  fetch_data_t     fd_p1;

`ifdef FETCH_MISALIGN_EN
  logic exc_p1;
  assign misalign = (state == S_REQ) && pc_misaligned(pc[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign handshake = (state == S_HOLD) && fd_p1.valid && bus.out_ready;

  pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc             (pc),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .advance        (handshake),
    .next_pc        (next_pc)
  );

  // A dropped request keeps presenting its original address until it returns.
  assign bus.ireq_valid = reset && (((state == S_REQ) && !misalign) || (state == S_DROP));
  assign bus.ireq_addr  = (state == S_DROP) ? stale_addr : pc;

  assign bus.out_valid = fd_p1.valid;
  assign bus.out_instr = fd_p1.raw_instr;
  assign bus.out_pc    = XLEN'(fd_p1.pc);
`ifdef FETCH_MISALIGN_EN
  assign bus.out_exc   = exc_p1;
`endif

  // Stage p1: F/D output register and fetch control
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_REQ;
      pc         <= PC_RESET;
      stale_addr <= PC_RESET;
      fd_p1      <= '0;
`ifdef FETCH_MISALIGN_EN
      exc_p1     <= 1'b0;
`endif
    end else begin
      pc <= next_pc;
      case (state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            if (!bus.iresp_data_ok && !misalign) begin
              stale_addr <= pc;
              state      <= S_DROP;
            end
          end else if (misalign) begin
            fd_p1 <= '{raw_instr: NOP_INSTR, pc: FETCH_XLEN'(pc), valid: 1'b1};
`ifdef FETCH_MISALIGN_EN
            exc_p1 <= 1'b1;
`endif
            state <= S_HOLD;
          end else if (bus.iresp_data_ok) begin
            fd_p1 <= '{raw_instr: bus.iresp_data, pc: FETCH_XLEN'(pc), valid: 1'b1};
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid || handshake) begin
            fd_p1.valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            exc_p1 <= 1'b0;
`endif
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.iresp_data_ok) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
